// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_seq_pkg : shared types and default widths for the sequencer |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package alu_seq_pkg;

  localparam int c_data_w        = 8;
  localparam int c_res_w         = 16;
  localparam int c_sel_w         = 3;
  localparam int c_num_ops       = 8;
  localparam int c_settle_cycles = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One captured ALU observation at the default result width.
  typedef struct packed {
    logic [c_res_w-1:0] res;
    logic               gt;
    logic               eq;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_buf.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_result_buf : per-op capture store, 1 write / 1 comb read    |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module alu_result_buf #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 3
) (
  input  logic              clk_in,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [WIDTH-1:0]  wr_data_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic [WIDTH-1:0]  rd_data_out
);

  // Data is qualified by the sequencer state, so no reset is needed here.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      r_mem[wr_addr_in] <= wr_data_in;
    end
  end

  assign rd_data_out = r_mem[rd_addr_in];

endmodule
`default_nettype wire

// File: rtl/alu_sweep_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_sweep_sequencer : sweeps an ALU through all ops per operand |
// | pair, buffers {res,gt,eq} and streams them out tagged by op.    |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module alu_sweep_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W        = c_data_w,
  parameter int RES_W         = c_res_w,
  parameter int SEL_W         = c_sel_w,
  parameter int NUM_OPS       = c_num_ops,
  parameter int SETTLE_CYCLES = c_settle_cycles
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy_out,
  output logic [DATA_W-1:0] d0_out,
  output logic [DATA_W-1:0] d1_out,
  output logic [SEL_W-1:0]  sel_out,
  input  logic [RES_W-1:0]  res_in,
  input  logic              gt_in,
  input  logic              eq_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [SEL_W-1:0]  tag_out,
  output logic [RES_W-1:0]  res_out,
  output logic              gt_out,
  output logic              eq_out,
  output logic              last_out
);

  localparam int                 c_cnt_w    = $clog2(SETTLE_CYCLES + 1);
  localparam int                 c_beat_w   = RES_W + 2;
  localparam logic [SEL_W-1:0]   c_last_op  = SEL_W'(NUM_OPS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [SEL_W-1:0]    r_rd_idx;
  logic [SEL_W-1:0]    w_rd_idx_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0]   r_d0;
  logic [DATA_W-1:0]   w_d0_nxt;
  logic [DATA_W-1:0]   r_d1;
  logic [DATA_W-1:0]   w_d1_nxt;
  logic                w_wr_en;
  logic                w_valid;
  logic [c_beat_w-1:0] w_wr_data;
  logic [c_beat_w-1:0] w_rd_data;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_rd_idx <= '0;
      r_cnt    <= '0;
      r_d0     <= '0;
      r_d1     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_rd_idx <= w_rd_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_d0     <= w_d0_nxt;
      r_d1     <= w_d1_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_rd_idx_nxt = r_rd_idx;
    w_cnt_nxt    = r_cnt;
    w_d0_nxt     = r_d0;
    w_d1_nxt     = r_d1;
    w_wr_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_d0_nxt    = a_in;
          w_d1_nxt    = b_in;
          w_sel_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = '0;
          // Comparing against the last op keeps sel from ever wrapping.
          if (r_sel == c_last_op) begin
            w_state_nxt  = DRAIN;
            w_rd_idx_nxt = '0;
          end else begin
            w_sel_nxt = r_sel + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (ready_in) begin
          if (r_rd_idx == c_last_op) begin
            w_state_nxt = IDLE;
          end else begin
            w_rd_idx_nxt = r_rd_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_wr_data = {res_in, gt_in, eq_in};

  alu_result_buf #(
    .DEPTH  (NUM_OPS),
    .WIDTH  (c_beat_w),
    .ADDR_W (SEL_W)
  ) u_buf (
    .clk_in      (clk_in),
    .wr_en_in    (w_wr_en),
    .wr_addr_in  (r_sel),
    .wr_data_in  (w_wr_data),
    .rd_addr_in  (r_rd_idx),
    .rd_data_out (w_rd_data)
  );

  // Beat outputs are gated so stale buffer contents never leak outside DRAIN.
  assign w_valid   = (r_state == DRAIN);
  assign valid_out = w_valid;
  assign busy_out  = (r_state != IDLE);
  assign d0_out    = r_d0;
  assign d1_out    = r_d1;
  assign sel_out   = r_sel;
  assign tag_out   = w_valid ? r_rd_idx : '0;
  assign res_out   = w_valid ? w_rd_data[c_beat_w-1:2] : '0;
  assign gt_out    = w_valid & w_rd_data[1];
  assign eq_out    = w_valid & w_rd_data[0];
  assign last_out  = w_valid & (r_rd_idx == c_last_op);

endmodule
`default_nettype wire

// File: tb/tb_alu_sweep_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_alu_sweep_sequencer : directed bench for the sweep sequencer |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_alu_sweep_sequencer;

  logic clk;
  logic rst_n;

  // Instance with SETTLE_CYCLES = 1
  logic        start, ready, busy, valid, gt_o, eq_o, last_o, gt_m, eq_m;
  logic [7:0]  a_in, b_in, d0, d1, sum_m;
  logic [2:0]  sel, tag;
  logic [15:0] res_o, res_m;

  // Instance with SETTLE_CYCLES = 3
  logic        s3_start, s3_ready, s3_busy, s3_valid, s3_gt, s3_eq, s3_last, s3_gt_m, s3_eq_m;
  logic [7:0]  s3_a, s3_b, s3_d0, s3_d1, s3_sum_m;
  logic [2:0]  s3_sel, s3_tag;
  logic [15:0] s3_res, s3_res_m;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] got_res [8];

  // Bench ALU models
  assign sum_m    = d0 + d1;
  assign res_m    = {5'd0, sel, sum_m};
  assign gt_m     = d1 > d0;
  assign eq_m     = d1 == d0;
  assign s3_sum_m = s3_d0 + s3_d1;
  assign s3_res_m = {5'd0, s3_sel, s3_sum_m};
  assign s3_gt_m  = s3_d1 > s3_d0;
  assign s3_eq_m  = s3_d1 == s3_d0;

  alu_sweep_sequencer dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .a_in(a_in), .b_in(b_in),
    .busy_out(busy), .d0_out(d0), .d1_out(d1), .sel_out(sel),
    .res_in(res_m), .gt_in(gt_m), .eq_in(eq_m),
    .valid_out(valid), .ready_in(ready), .tag_out(tag), .res_out(res_o),
    .gt_out(gt_o), .eq_out(eq_o), .last_out(last_o)
  );

  alu_sweep_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(s3_start), .a_in(s3_a), .b_in(s3_b),
    .busy_out(s3_busy), .d0_out(s3_d0), .d1_out(s3_d1), .sel_out(s3_sel),
    .res_in(s3_res_m), .gt_in(s3_gt_m), .eq_in(s3_eq_m),
    .valid_out(s3_valid), .ready_in(s3_ready), .tag_out(s3_tag), .res_out(s3_res),
    .gt_out(s3_gt), .eq_out(s3_eq), .last_out(s3_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag_s, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag_s, got, exp);
    end
  endtask

  // One full job on the SETTLE_CYCLES=1 instance.
  // rmode 0: ready always high; rmode 1: ready pattern 1,0,0 repeating.
  // poke: pulse a second start during SWEEP and hold it high through DRAIN.
  task automatic job(input logic [7:0] a, input logic [7:0] b, input int rmode, input bit poke);
    int         idx;
    int         cyc;
    logic [7:0] s;
    s = a + b;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_accept", busy, 1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("sel_sweep", sel, k);
      check("d0_hold", d0, a);
      check("d1_hold", d1, b);
      check("valid_sweep", valid, 0);
      if (poke) begin
        start = (k == 3); a_in = 8'd7; b_in = 8'd9;
      end
    end
    @(negedge clk);
    start = poke;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      check("valid_drain", valid, 1);
      check("busy_drain", busy, 1);
      check("tag", tag, idx);
      check("res", res_o, {8'(idx), s});
      check("gt", gt_o, b > a);
      check("eq", eq_o, a == b);
      check("last", last_o, idx == 7);
      check("sel_final", sel, 7);
      got_res[idx] = res_o;
      ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (ready) idx++;
      cyc++;
      @(negedge clk);
    end
    check("drain_count", idx, 8);
    start = 1'b0;
    ready = 1'b0;
    check("valid_after", valid, 0);
    check("busy_after", busy, 0);
    check("sel_idle_hold", sel, 7);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; ready = 1'b0; a_in = '0; b_in = '0;
    s3_start = 1'b0; s3_ready = 1'b0; s3_a = '0; s3_b = '0;

    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_sel", sel, 0);
    check("rst_d0", d0, 0);
    check("rst_d1", d1, 0);
    check("rst_res", res_o, 0);
    check("rst_last", last_o, 0);
    check("rst3_valid", s3_valid, 0);
    rst_n = 1'b1;

    // Basic sweep
    job(8'd12, 8'd45, 0, 1'b0);
    check("basic_res0", got_res[0], 16'h0039);
    check("basic_res1", got_res[1], 16'h0139);
    check("basic_res7", got_res[7], 16'h0739);

    // Backpressure, equal operands with 8-bit wrap
    job(8'd200, 8'd200, 1, 1'b0);
    check("bp_res0", got_res[0], 16'h0090);
    check("bp_res5", got_res[5], 16'h0590);

    // Start while busy is ignored; next job is taken normally
    job(8'd5, 8'd6, 0, 1'b1);
    job(8'd7, 8'd9, 0, 1'b0);
    check("next_job_lo", got_res[4][7:0], 8'h10);

    // Settle time of 3 cycles per op
    @(negedge clk);
    s3_start = 1'b1; s3_a = 8'd1; s3_b = 8'd2;
    @(negedge clk);
    s3_start = 1'b0; s3_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      check("s3_sel", s3_sel, k / 3);
      check("s3_valid_sweep", s3_valid, 0);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("s3_valid", s3_valid, 1);
      check("s3_tag", s3_tag, i);
      check("s3_res", s3_res, {8'(i), 8'h03});
      check("s3_gt", s3_gt, 1);
      check("s3_eq", s3_eq, 0);
      check("s3_last", s3_last, i == 7);
      @(negedge clk);
    end
    check("s3_valid_end", s3_valid, 0);
    check("s3_busy_end", s3_busy, 0);
    s3_ready = 1'b0;

    // Asynchronous reset in the middle of DRAIN
    @(negedge clk);
    start = 1'b1; a_in = 8'd3; b_in = 8'd4;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    for (int i = 0; i < 50 && !valid; i++) @(negedge clk);
    check("rst_reach_drain", valid, 1);
    repeat (4) @(negedge clk);
    check("rst_pre_tag", tag, 4);
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sel", sel, 0);
    check("arst_tag", tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    job(8'd0, 8'd0, 0, 1'b0);
    check("fresh_res0", got_res[0], 16'h0000);
    check("fresh_res7", got_res[7], 16'h0700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
